ro_trng_ctrl: RTL and testbench
===============================

# ro_trng_ctrl

Sequencer for the ring-oscillator entropy datapath. Enables both oscillators, waits out a warm-up period, and samples the buffer's lowest byte lane once every 8 clocks so that consecutive bytes never share shift-register bits. It screens each byte with a repetition health test and delivers a requested number of bytes through a 4-entry FIFO with a valid/ready handshake. It sits between the oscillator buffer (out_sel/out) and the consumer, such as a host register interface.

## Interface
Parameters:
- WARMUP_CYCLES, 256: clocks with oscillators enabled before fill starts (≥1).
- PIPE_LAT, 3: clocks from oscillator edge to the buffer's registered byte output (ro sample reg, shift, out reg).
- HEALTH_LIMIT, 4: consecutive identical sampled bytes that trip the health test (≥2).

Ports:
- clk, in, 1: single clock. All logic is on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle request pulse. Accepted only in IDLE with health_fail=0.
- req_len, in, 8: bytes to deliver, captured on start. 0 means 256.
- ro_activate_1, out, 1: enable for oscillator 1.
- ro_activate_2, out, 1: enable for oscillator 2.
- out_sel, out, 3: buffer lane select. Constant 3'b000.
- ro_byte, in, 8: registered byte from the buffer.
- rnd_data, out, 8: FIFO head byte.
- rnd_valid, out, 1: FIFO not empty.
- rnd_ready, in, 1: consumer pops the head when rnd_valid & rnd_ready.
- busy, out, 1: state≠IDLE or FIFO not empty.
- health_fail, out, 1: sticky repetition-test failure flag.
- clear_fail, in, 1: synchronous clear of health_fail.

## Operation
- States: IDLE, WARMUP, FILL, RUN.
- IDLE:
  - Oscillators off.
  - On accepted start: rem←(req_len==0 ? 256 : req_len), where rem is 9 bits. Then go to WARMUP and clear the warm-up counter.
- WARMUP:
  - Both ro_activate high.
  - After WARMUP_CYCLES clocks, go to FILL.
- FILL:
  - Oscillators on.
  - Lasts 8+PIPE_LAT clocks so lane 0 holds only post-warm-up bits. Then go to RUN with phase=0.
- RUN:
  - Oscillators on. A 3-bit phase counter increments every clock.
  - A sample slot occurs on each clock where phase==7. At each slot ro_byte is evaluated.
- Health test, applied to every slot byte, including dropped ones:
  - If the byte equals the previous slot byte, rep_cnt increments. Otherwise rep_cnt←1.
  - If rep_cnt reaches HEALTH_LIMIT: set health_fail, discard the byte, and go to IDLE (oscillators off). FIFO contents are retained.
  - rep_cnt and the previous-byte register clear on every start.
- Byte acceptance at a slot (byte passes the health test):
  - FIFO not full: push the byte and decrement rem. If rem reaches 0, go to IDLE.
  - FIFO full: drop the byte. rem is unchanged and the oscillators stay on.
- FIFO:
  - 4 entries, 2-bit pointers plus a 3-bit count.
  - Push and pop in the same cycle while full or empty are both legal. Count is unchanged.
  - A pop on an empty FIFO is ignored.
- clear_fail clears health_fail in any state. If clear_fail coincides with a failure in the same cycle, the failure wins.
- start while busy, or while health_fail=1, is ignored with no side effects.

## Timing
- Reset values: ro_activate_1/2=0, out_sel=000, rnd_valid=0, rnd_data=00, busy=0, health_fail=0, state=IDLE, FIFO empty, rem=0, rep_cnt=0.
- Async reset mid-operation forces all of the above immediately. The oscillators stop the same instant.
- Start accepted at edge t:
  - ro_activate rises at t+1.
  - FILL is entered at t+1+WARMUP_CYCLES.
  - The first slot is at t+1+WARMUP_CYCLES+8+PIPE_LAT+7. With defaults this is t+275.
- Slots are spaced exactly 8 clocks apart.
- A pushed byte appears on rnd_data/rnd_valid on the clock after the slot.
- busy rises the clock after start and falls the clock after the last pop.
- The last push deasserts ro_activate on the following clock.

## Test plan
- Reset, then start with req_len=3 and rnd_ready=1 held:
  - ro_activate high from t+1.
  - Exactly 3 bytes arrive, equal to ro_byte at t+275, t+283 and t+291.
  - ro_activate low at t+292; busy low after the last pop.
- req_len=6 with rnd_ready=0:
  - FIFO fills to 4.
  - Slots 5 and 6 are dropped and the oscillators stay on.
  - Raise rnd_ready: 6 bytes are delivered in total, all slot-aligned.
- Force ro_byte=8'hA5 constantly:
  - health_fail sets at the 4th slot and the FSM returns to IDLE.
  - A following start is ignored.
  - Pulse clear_fail, then start again: the request is accepted.
- Assert rst_n=0 mid-RUN with 2 bytes queued:
  - All outputs return to reset values asynchronously.
  - The FIFO is empty after release.
- req_len=0 delivers 256 bytes. A start pulse while busy=1 is ignored and the count is unchanged.

Source files
------------

// File: rtl/ro_trng_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ro_trng_ctrl
// Brief    : Ring-oscillator TRNG sequencer: warm-up, decimated byte sampling,
//            repetition health test and a 4-entry valid/ready output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ro_trng_ctrl #(
  parameter int WARMUP_CYCLES = 256,
  parameter int PIPE_LAT      = 3,
  parameter int HEALTH_LIMIT  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] req_len,
  output logic       ro_activate_1,
  output logic       ro_activate_2,
  output logic [2:0] out_sel,
  input  logic [7:0] ro_byte,
  output logic [7:0] rnd_data,
  output logic       rnd_valid,
  input  logic       rnd_ready,
  output logic       busy,
  output logic       health_fail,
  input  logic       clear_fail
);

  localparam int c_fill_cycles = 8 + PIPE_LAT;
  localparam int c_cnt_max     = (WARMUP_CYCLES > c_fill_cycles) ? WARMUP_CYCLES : c_fill_cycles;
  localparam int c_cnt_w       = $clog2(c_cnt_max + 1);
  localparam int c_rep_w       = $clog2(HEALTH_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_FILL   = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_ro_act;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [2:0]           r_phase;
  logic [8:0]           r_rem;
  logic [c_rep_w-1:0]   r_rep;
  logic [7:0]           r_prev;
  logic                 r_health_fail;

  logic [7:0]           r_mem [4];
  logic [1:0]           r_wr;
  logic [1:0]           r_rd;
  logic [2:0]           r_count;

  logic                 w_pop;
  logic                 w_slot;
  logic                 w_same;
  logic [c_rep_w-1:0]   w_rep_next;
  logic                 w_trip;
  logic                 w_push;
  logic                 w_start_ok;

  assign w_pop      = rnd_ready && (r_count != 3'd0);
  assign w_slot     = (r_state == S_RUN) && (r_phase == 3'd7);
  // r_rep==0 marks "no previous slot byte since start", so the first byte never counts as a repeat
  assign w_same     = (r_rep != '0) && (ro_byte == r_prev);
  assign w_rep_next = w_same ? (r_rep + c_rep_w'(1)) : c_rep_w'(1);
  assign w_trip     = w_slot && (w_rep_next >= c_rep_w'(HEALTH_LIMIT));
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign w_push     = w_slot && !w_trip && ((r_count != 3'd4) || w_pop);
  assign w_start_ok = start && (r_state == S_IDLE) && (r_count == 3'd0) && !r_health_fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_ro_act      <= 1'b0;
      r_cnt         <= '0;
      r_phase       <= 3'd0;
      r_rem         <= 9'd0;
      r_rep         <= '0;
      r_prev        <= 8'h00;
      r_health_fail <= 1'b0;
    end else begin
      if (w_trip)
        r_health_fail <= 1'b1;
      else if (clear_fail)
        r_health_fail <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_rem    <= (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
            r_rep    <= '0;
            r_prev   <= 8'h00;
            r_cnt    <= '0;
            r_ro_act <= 1'b1;
            r_state  <= S_WARMUP;
          end
        end
        S_WARMUP: begin
          if (r_cnt == c_cnt_w'(WARMUP_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_state <= S_FILL;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        S_FILL: begin
          // flush lane 0 of any bits captured before warm-up completed
          if (r_cnt == c_cnt_w'(c_fill_cycles - 1)) begin
            r_cnt   <= '0;
            r_phase <= 3'd0;
            r_state <= S_RUN;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        S_RUN: begin
          r_phase <= r_phase + 3'd1;
          if (w_slot) begin
            r_rep  <= w_rep_next;
            r_prev <= ro_byte;
            if (w_trip) begin
              r_ro_act <= 1'b0;
              r_state  <= S_IDLE;
            end else if (w_push) begin
              r_rem <= r_rem - 9'd1;
              if (r_rem == 9'd1) begin
                r_ro_act <= 1'b0;
                r_state  <= S_IDLE;
              end
            end
          end
        end
        default: begin
          r_ro_act <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++)
        r_mem[i] <= 8'h00;
      r_wr    <= 2'd0;
      r_rd    <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= ro_byte;
        r_wr        <= r_wr + 2'd1;
      end
      if (w_pop)
        r_rd <= r_rd + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign ro_activate_1 = r_ro_act;
  assign ro_activate_2 = r_ro_act;
  assign out_sel       = 3'b000;
  assign rnd_data      = r_mem[r_rd];
  assign rnd_valid     = (r_count != 3'd0);
  assign busy          = (r_state != S_IDLE) || (r_count != 3'd0);
  assign health_fail   = r_health_fail;

endmodule
`default_nettype wire

// File: tb/tb_ro_trng_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ro_trng_ctrl
// Brief    : Directed self-checking bench for ro_trng_ctrl (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ro_trng_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] req_len;
  logic       ro_activate_1;
  logic       ro_activate_2;
  logic [2:0] out_sel;
  logic [7:0] ro_byte;
  logic [7:0] rnd_data;
  logic       rnd_valid;
  logic       rnd_ready;
  logic       busy;
  logic       health_fail;
  logic       clear_fail;

  logic        force_a5;
  logic [31:0] cyc;
  logic [7:0]  rx_q [$];
  int          n_checks;
  int          n_errors;
  logic [31:0] t0;

  ro_trng_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .req_len       (req_len),
    .ro_activate_1 (ro_activate_1),
    .ro_activate_2 (ro_activate_2),
    .out_sel       (out_sel),
    .ro_byte       (ro_byte),
    .rnd_data      (rnd_data),
    .rnd_valid     (rnd_valid),
    .rnd_ready     (rnd_ready),
    .busy          (busy),
    .health_fail   (health_fail),
    .clear_fail    (clear_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc holds, between edges, the index of the next rising edge
  initial cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  function automatic logic [7:0] exp_byte(input logic [31:0] c);
    return c[7:0] ^ 8'h5A;
  endfunction

  assign ro_byte = force_a5 ? 8'hA5 : exp_byte(cyc);

  always @(negedge clk)
    if (rnd_valid && rnd_ready)
      rx_q.push_back(rnd_data);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_edge(input logic [31:0] k);
    while (cyc <= k) step();
  endtask

  task automatic pulse_start(input logic [7:0] len);
    req_len = len;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i;
    i = 0;
    while (busy && i < budget) begin
      step();
      i++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int ks[6];
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    req_len    = 8'd0;
    rnd_ready  = 1'b0;
    clear_fail = 1'b0;
    force_a5   = 1'b0;
    repeat (3) step();

    check("rst_ro1",   {31'd0, ro_activate_1}, 32'd0);
    check("rst_ro2",   {31'd0, ro_activate_2}, 32'd0);
    check("rst_sel",   {29'd0, out_sel}, 32'd0);
    check("rst_valid", {31'd0, rnd_valid}, 32'd0);
    check("rst_data",  {24'd0, rnd_data}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_hf",    {31'd0, health_fail}, 32'd0);
    rst_n = 1'b1;
    step();

    // Basic 3-byte request with consumer always ready
    rnd_ready = 1'b1;
    t0 = cyc;
    pulse_start(8'd3);
    check("t1_ro1_on",  {31'd0, ro_activate_1}, 32'd1);
    check("t1_ro2_on",  {31'd0, ro_activate_2}, 32'd1);
    check("t1_busy",    {31'd0, busy}, 32'd1);
    wait_edge(t0 + 274);
    check("t1_no_early", {31'd0, rnd_valid}, 32'd0);
    wait_edge(t0 + 275);
    check("t1_first_valid", {31'd0, rnd_valid}, 32'd1);
    check("t1_first_data", {24'd0, rnd_data}, {24'd0, exp_byte(t0 + 275)});
    wait_edge(t0 + 290);
    check("t1_ro_on_290", {31'd0, ro_activate_1}, 32'd1);
    wait_edge(t0 + 291);
    check("t1_ro_off_292", {31'd0, ro_activate_1}, 32'd0);
    wait_edge(t0 + 292);
    check("t1_busy_low", {31'd0, busy}, 32'd0);
    check("t1_count", rx_q.size(), 32'd3);
    for (int i = 0; i < 3 && i < rx_q.size(); i++)
      check("t1_byte", {24'd0, rx_q[i]}, {24'd0, exp_byte(t0 + 275 + 8 * i)});

    // Backpressure: FIFO fills, slots 5 and 6 dropped
    rx_q.delete();
    rnd_ready = 1'b0;
    step();
    t0 = cyc;
    pulse_start(8'd6);
    wait_edge(t0 + 315);
    check("t2_valid", {31'd0, rnd_valid}, 32'd1);
    check("t2_ro_on", {31'd0, ro_activate_1}, 32'd1);
    check("t2_none_popped", rx_q.size(), 32'd0);
    rnd_ready = 1'b1;
    wait_idle("t2_idle", 400);
    check("t2_count", rx_q.size(), 32'd6);
    ks = '{0, 1, 2, 3, 6, 7};
    for (int i = 0; i < 6 && i < rx_q.size(); i++)
      check("t2_byte", {24'd0, rx_q[i]}, {24'd0, exp_byte(t0 + 275 + 8 * ks[i])});
    check("t2_ro_off", {31'd0, ro_activate_1}, 32'd0);

    // Repetition health test
    rx_q.delete();
    force_a5 = 1'b1;
    step();
    t0 = cyc;
    pulse_start(8'd10);
    wait_edge(t0 + 298);
    check("t3_hf_before", {31'd0, health_fail}, 32'd0);
    wait_edge(t0 + 299);
    check("t3_hf_set", {31'd0, health_fail}, 32'd1);
    check("t3_ro_off", {31'd0, ro_activate_1}, 32'd0);
    wait_idle("t3_idle", 20);
    check("t3_count", rx_q.size(), 32'd3);
    for (int i = 0; i < 3 && i < rx_q.size(); i++)
      check("t3_byte", {24'd0, rx_q[i]}, 32'hA5);
    pulse_start(8'd2);
    check("t3_start_ignored_busy", {31'd0, busy}, 32'd0);
    check("t3_start_ignored_ro", {31'd0, ro_activate_1}, 32'd0);
    clear_fail = 1'b1;
    step();
    clear_fail = 1'b0;
    check("t3_hf_cleared", {31'd0, health_fail}, 32'd0);
    force_a5 = 1'b0;
    rx_q.delete();
    t0 = cyc;
    pulse_start(8'd1);
    check("t3_restart_busy", {31'd0, busy}, 32'd1);
    check("t3_restart_ro", {31'd0, ro_activate_1}, 32'd1);
    wait_idle("t3_restart_idle", 400);
    check("t3_restart_count", rx_q.size(), 32'd1);
    if (rx_q.size() > 0)
      check("t3_restart_byte", {24'd0, rx_q[0]}, {24'd0, exp_byte(t0 + 275)});

    // Asynchronous reset mid-RUN with 2 bytes queued
    rx_q.delete();
    rnd_ready = 1'b0;
    step();
    t0 = cyc;
    pulse_start(8'd5);
    wait_edge(t0 + 283);
    check("t4_queued", {31'd0, rnd_valid}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("t4_ro_off",  {31'd0, ro_activate_1}, 32'd0);
    check("t4_valid",   {31'd0, rnd_valid}, 32'd0);
    check("t4_data",    {24'd0, rnd_data}, 32'd0);
    check("t4_busy",    {31'd0, busy}, 32'd0);
    step();
    rst_n = 1'b1;
    rnd_ready = 1'b1;
    repeat (3) step();
    check("t4_empty_after", {31'd0, rnd_valid}, 32'd0);
    check("t4_none_popped", rx_q.size(), 32'd0);

    // req_len=0 means 256 bytes; start while busy is ignored
    rx_q.delete();
    t0 = cyc;
    pulse_start(8'd0);
    wait_edge(t0 + 400);
    pulse_start(8'd5);
    wait_idle("t5_idle", 3000);
    check("t5_count", rx_q.size(), 32'd256);
    for (int i = 0; i < 256 && i < rx_q.size(); i++)
      check("t5_byte", {24'd0, rx_q[i]}, {24'd0, exp_byte(t0 + 275 + 8 * i)});
    repeat (20) step();
    check("t5_no_extra", rx_q.size(), 32'd256);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
